// File: rtl/vend_pkg.sv
// Shared types and constants for the coin change dispenser.
package vend_pkg;

  localparam logic [7:0] COIN_25 = 8'd25;
  localparam logic [7:0] COIN_10 = 8'd10;
  localparam logic [7:0] COIN_5  = 8'd5;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE
  } disp_state_t;

  typedef enum logic [1:0] {
    NONE,
    Q,
    D,
    N
  } coin_t;

  function automatic logic [7:0] coin_value(input coin_t c);
    case (c)
      Q:       coin_value = COIN_25;
      D:       coin_value = COIN_10;
      N:       coin_value = COIN_5;
      default: coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter with a zero flag; times both the solenoid pulse and the gap.
module dispense_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount as 25/10/5 cent coins, largest first, one solenoid pulse per coin.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  amount,
  input  logic        empty_25,
  input  logic        empty_10,
  input  logic        empty_5,
  output logic        busy,
  output logic        eject_25,
  output logic        eject_10,
  output logic        eject_5,
  output logic        done,
  output logic [5:0]  coins_paid,
  output logic [7:0]  shortfall,
  output logic        error,
  output disp_state_t dbg_state
);

  // Handshake: start is a single-cycle request with no ready; it is accepted
  // only in IDLE (busy low) and silently dropped otherwise.

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  disp_state_t   state;
  logic [7:0]    remaining;
  coin_t         pick;
  logic          timer_load;
  logic [CW-1:0] timer_value;
  logic          timer_zero;

  // Greedy choice on the current remaining value and live tube sensors.
  always_comb begin
    pick = NONE;
    if (remaining >= COIN_25 && !empty_25) begin
      pick = Q;
    end else if (remaining >= COIN_10 && !empty_10) begin
      pick = D;
    end else if (remaining >= COIN_5 && !empty_5) begin
      pick = N;
    end
  end

  always_comb begin
    timer_load  = 1'b0;
    timer_value = GAP_LOAD;
    if (state == SELECT && pick != NONE) begin
      timer_load  = 1'b1;
      timer_value = PULSE_LOAD;
    end else if (state == PULSE && timer_zero) begin
      timer_load  = 1'b1;
    end
  end

  dispense_timer #(
    .W(CW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      remaining  <= 8'd0;
      busy       <= 1'b0;
      eject_25   <= 1'b0;
      eject_10   <= 1'b0;
      eject_5    <= 1'b0;
      done       <= 1'b0;
      coins_paid <= 6'd0;
      shortfall  <= 8'd0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining  <= amount;
            coins_paid <= 6'd0;
            shortfall  <= 8'd0;
            error      <= 1'b0;
            busy       <= 1'b1;
            state      <= SELECT;
          end
        end
        SELECT: begin
          if (pick != NONE) begin
            remaining  <= remaining - coin_value(pick);
            coins_paid <= coins_paid + 6'd1;
            eject_25   <= (pick == Q);
            eject_10   <= (pick == D);
            eject_5    <= (pick == N);
            state      <= PULSE;
          end else begin
            shortfall <= remaining;
            error     <= (remaining != 8'd0);
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        PULSE: begin
          if (timer_zero) begin
            eject_25 <= 1'b0;
            eject_10 <= 1'b0;
            eject_5  <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (timer_zero) begin
            state <= SELECT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized payouts against a greedy coin model.
module tb_change_dispenser;

  localparam int P      = 4;
  localparam int G      = 2;
  localparam int COIN_T = 1 + P + G;
  localparam int MAXC   = 420;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       empty_25 = 1'b0;
  logic       empty_10 = 1'b0;
  logic       empty_5 = 1'b0;
  logic       busy;
  logic       eject_25;
  logic       eject_10;
  logic       eject_5;
  logic       done;
  logic [5:0] coins_paid;
  logic [7:0] shortfall;
  logic       error;
  vend_pkg::disp_state_t dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [2:0] emp [0:MAXC];

  change_dispenser #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .amount     (amount),
    .empty_25   (empty_25),
    .empty_10   (empty_10),
    .empty_5    (empty_5),
    .busy       (busy),
    .eject_25   (eject_25),
    .eject_10   (eject_10),
    .eject_5    (eject_5),
    .done       (done),
    .coins_paid (coins_paid),
    .shortfall  (shortfall),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Drives one request at cycle 0 and checks every cycle until one past done.
  // Tube sensors come from emp[cycle]; the model consults them only at SELECT cycles.
  task automatic run_payout(input logic [7:0] amt, input logic [2:0] base, input bit jitter,
                            input int extra_start, output int obs_done,
                            output logic [5:0] obs_coins, output logic [7:0] obs_short);
    int coin_val[$];
    int rem;
    int t;
    int v;
    int exp_done;
    int k;
    int off;
    logic [2:0] exp_ej;
    logic [2:0] got_ej;
    for (int c = 0; c <= MAXC; c++) begin
      emp[c] = jitter ? 3'($urandom_range(0, 7)) : base;
    end
    rem = amt;
    t = 1;
    forever begin
      if (rem >= 25 && !emp[t][2]) v = 25;
      else if (rem >= 10 && !emp[t][1]) v = 10;
      else if (rem >= 5 && !emp[t][0]) v = 5;
      else break;
      coin_val.push_back(v);
      rem -= v;
      t += COIN_T;
    end
    exp_done = t + 1;
    obs_done = -1;

    @(negedge clk);
    {empty_25, empty_10, empty_5} = emp[0];
    amount = amt;
    start = 1'b1;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      start = (c == extra_start);
      if (c == extra_start) amount = 8'($urandom_range(30, 255));
      {empty_25, empty_10, empty_5} = emp[c];
      exp_ej = 3'b000;
      if (c >= 2) begin
        k = (c - 2) / COIN_T;
        off = (c - 2) % COIN_T;
        if (k < coin_val.size() && off < P) begin
          exp_ej = (coin_val[k] == 25) ? 3'b100 : (coin_val[k] == 10) ? 3'b010 : 3'b001;
        end
      end
      got_ej = {eject_25, eject_10, eject_5};
      n_checks++;
      if (got_ej !== exp_ej)
        $display("FAIL eject amt=%0d cycle=%0d got=%b want=%b", amt, c, got_ej, exp_ej);
      else n_pass++;
      n_checks++;
      if (done !== (c == exp_done))
        $display("FAIL done amt=%0d cycle=%0d got=%b want=%b", amt, c, done, (c == exp_done));
      else n_pass++;
      n_checks++;
      if (busy !== (c <= exp_done))
        $display("FAIL busy amt=%0d cycle=%0d got=%b want=%b", amt, c, busy, (c <= exp_done));
      else n_pass++;
      if (done === 1'b1 && obs_done < 0) obs_done = c;
      if (c == exp_done) begin
        n_checks++;
        if (coins_paid !== 6'(coin_val.size()))
          $display("FAIL coins_paid amt=%0d got=%0d want=%0d", amt, coins_paid, coin_val.size());
        else n_pass++;
        n_checks++;
        if (shortfall !== 8'(rem))
          $display("FAIL shortfall amt=%0d got=%0d want=%0d", amt, shortfall, rem);
        else n_pass++;
        n_checks++;
        if (error !== (rem != 0))
          $display("FAIL error amt=%0d got=%b want=%b", amt, error, (rem != 0));
        else n_pass++;
      end
    end
    start = 1'b0;
    obs_coins = coins_paid;
    obs_short = shortfall;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, eject_25, eject_10, eject_5, done, error} !== 6'b0)
      $display("FAIL reset_flags got=%b want=000000", {busy, eject_25, eject_10, eject_5, done, error});
    else n_pass++;
    n_checks++;
    if (coins_paid !== 6'd0 || shortfall !== 8'd0)
      $display("FAIL reset_counts got=%0d/%0d want=0/0", coins_paid, shortfall);
    else n_pass++;
    n_checks++;
    if (dbg_state !== vend_pkg::IDLE)
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, vend_pkg::IDLE);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_payout();
    int d;
    logic [5:0] cp;
    logic [7:0] sf;
    run_payout(8'd40, 3'b000, 1'b0, -1, d, cp, sf);
    n_checks++;
    if (d !== 23 || cp !== 6'd3 || sf !== 8'd0)
      $display("FAIL full_payout got done=%0d coins=%0d short=%0d want 23/3/0", d, cp, sf);
    else n_pass++;
  endtask

  task automatic test_empty_quarter();
    int d;
    logic [5:0] cp;
    logic [7:0] sf;
    run_payout(8'd30, 3'b100, 1'b0, -1, d, cp, sf);
    n_checks++;
    if (d !== 23 || cp !== 6'd3)
      $display("FAIL empty_quarter got done=%0d coins=%0d want 23/3", d, cp);
    else n_pass++;
  endtask

  task automatic test_residue();
    int d;
    logic [5:0] cp;
    logic [7:0] sf;
    run_payout(8'd42, 3'b000, 1'b0, -1, d, cp, sf);
    n_checks++;
    if (sf !== 8'd2 || error !== 1'b1 || cp !== 6'd3)
      $display("FAIL residue got short=%0d error=%b coins=%0d want 2/1/3", sf, error, cp);
    else n_pass++;
  endtask

  task automatic test_no_payable();
    int d;
    logic [5:0] cp;
    logic [7:0] sf;
    run_payout(8'd15, 3'b011, 1'b0, -1, d, cp, sf);
    n_checks++;
    if (d !== 2 || sf !== 8'd15 || cp !== 6'd0)
      $display("FAIL no_payable got done=%0d short=%0d coins=%0d want 2/15/0", d, sf, cp);
    else n_pass++;
  endtask

  task automatic test_zero_and_busy_start();
    int d;
    logic [5:0] cp;
    logic [7:0] sf;
    run_payout(8'd0, 3'b000, 1'b0, -1, d, cp, sf);
    n_checks++;
    if (d !== 2 || sf !== 8'd0)
      $display("FAIL zero_amount got done=%0d short=%0d want 2/0", d, sf);
    else n_pass++;
    run_payout(8'd25, 3'b000, 1'b0, 4, d, cp, sf);
    n_checks++;
    if (cp !== 6'd1 || d !== 9)
      $display("FAIL busy_start got coins=%0d done=%0d want 1/9", cp, d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    int d;
    logic [5:0] cp;
    logic [7:0] sf;
    @(negedge clk);
    {empty_25, empty_10, empty_5} = 3'b000;
    amount = 8'd25;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (eject_25 !== 1'b1)
      $display("FAIL pre_reset_eject got=%b want=1", eject_25);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (eject_25 !== 1'b0 || busy !== 1'b0 || coins_paid !== 6'd0)
      $display("FAIL mid_pulse_reset got eject=%b busy=%b coins=%0d want 0/0/0", eject_25, busy, coins_paid);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    run_payout(8'd10, 3'b000, 1'b0, -1, d, cp, sf);
    n_checks++;
    if (cp !== 6'd1 || d !== 9)
      $display("FAIL after_reset got coins=%0d done=%0d want 1/9", cp, d);
    else n_pass++;
  endtask

  task automatic test_random();
    int d;
    logic [5:0] cp;
    logic [7:0] sf;
    for (int i = 0; i < 20; i++) begin
      run_payout(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), -1, d, cp, sf);
    end
  endtask

  initial begin
    test_reset();
    test_full_payout();
    test_empty_quarter();
    test_residue();
    test_no_payable();
    test_zero_and_busy_start();
    test_reset_mid_pulse();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
